gf2_poly_divider: RTL and testbench

GF2_POLY_DIVIDER -- requirements
Module: gf2_poly_divider

---
 rtl/gf2_div_pkg.sv | 57 +++++
 rtl/gf2_degree_enc.sv | 30 +++
 rtl/gf2_poly_divider.sv | 176 +++++++++++++++++
 tb/tb_gf2_poly_divider.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gf2_div_pkg
//  Description : Shared constants, FSM state type and the single-bit
//                long-division step used by the GF(2) polynomial divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package gf2_div_pkg;

   // Operand geometry: divisor/remainder width, dividend/quotient width,
   // and the width of a degree index (0..570).
   localparam int N  = 571;
   localparam int PW = 1142;
   localparam int DW = 10;

   // Width of the RUN step counter (must hold PW-1).
   localparam int CW = 11;

   // RUN length for each datapath rate.
   localparam int STEPS_RADIX2 = PW;
   localparam int STEPS_RADIX4 = PW / 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Result of one long-division step: the quotient bit it produced and
   // the updated partial remainder.
   typedef struct packed {
      logic         qbit;
      logic [N-1:0] rem;
   } step_t;

   // Shift the next dividend bit into the partial remainder; when the bit
   // at the divisor's degree becomes set, subtract (XOR) the divisor and
   // emit a quotient 1.  The partial remainder always has degree below
   // deg(divisor) before the shift, so the bit shifted out is always 0.
   function automatic step_t div_step(
      input logic [N-1:0]  rem,
      input logic [N-1:0]  dvs,
      input logic [DW-1:0] deg,
      input logic          bit_in
   );
      step_t s;
      s.rem  = {rem[N-2:0], bit_in};
      s.qbit = s.rem[deg];
      if (s.qbit) begin
         s.rem = s.rem ^ dvs;
      end
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gf2_degree_enc.sv
`default_nettype none
// ============================================================================
//  Module      : gf2_degree_enc
//  Description : Combinational highest-set-bit encoder for a 571-bit GF(2)
//                polynomial.  Returns the degree and a zero flag; the degree
//                output is 0 when the input is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf2_degree_enc
   import gf2_div_pkg::*;
(
   input  logic [N-1:0]  poly_i,
   output logic [DW-1:0] deg_o,
   output logic          zero_o
);

   // Ascending scan: the last set bit seen is the highest one.
   always_comb begin
      deg_o = '0;
      for (int i = 0; i < N; i++) begin
         if (poly_i[i]) begin
            deg_o = DW'(i);
         end
      end
   end

   assign zero_o = ~|poly_i;

endmodule
`default_nettype wire

// File: rtl/gf2_poly_divider.sv
`default_nettype none
// ============================================================================
//  Module      : gf2_poly_divider
//  Description : Sequential GF(2) polynomial long divider.  A 1142-bit
//                dividend is divided by a 571-bit divisor, MSB first, one
//                dividend bit per RUN cycle.  Quotient and remainder are
//                held from DONE until the next accepted start.
//  Config      : GF2_DIV_RADIX4_EN - when defined, two chained division
//                steps per RUN cycle (571 RUN cycles instead of 1142).
//  Revision    : 1.0 - initial release
// ============================================================================
module gf2_poly_divider
   import gf2_div_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [PW-1:0] dividend,
   input  logic [N-1:0]  divisor,
   output logic          busy,
   output logic          done,
   output logic          dbz,
   output logic [PW-1:0] quotient,
   output logic [N-1:0]  remainder
);

`ifdef GF2_DIV_RADIX4_EN
   localparam int RUN_STEPS = STEPS_RADIX4;
`else
   localparam int RUN_STEPS = STEPS_RADIX2;
`endif

   state_t          state_q, state_d;
   logic [PW-1:0]   dvd_q, dvd_d;      // dividend, consumed MSB first
   logic [N-1:0]    dvs_q, dvs_d;      // registered divisor
   logic [DW-1:0]   deg_q, deg_d;      // deg(divisor)
   logic [N-1:0]    rem_q, rem_d;      // partial remainder
   logic [PW-1:0]   quo_q, quo_d;      // quotient, built by left shift
   logic [CW-1:0]   cnt_q, cnt_d;      // RUN cycles remaining minus one
   logic            dbz_q, dbz_d;

   logic [DW-1:0]   w_enc_deg;
   logic            w_enc_zero;
   step_t           w_step_hi;
`ifdef GF2_DIV_RADIX4_EN
   step_t           w_step_lo;
`endif

   gf2_degree_enc u_degree_enc (
      .poly_i (dvs_q),
      .deg_o  (w_enc_deg),
      .zero_o (w_enc_zero)
   );

   // Division step(s) for the current RUN cycle; the second step in
   // radix-4 mode consumes the remainder of the first.
   always_comb begin
      w_step_hi = div_step(rem_q, dvs_q, deg_q, dvd_q[PW-1]);
`ifdef GF2_DIV_RADIX4_EN
      w_step_lo = div_step(w_step_hi.rem, dvs_q, deg_q, dvd_q[PW-2]);
`endif
   end

   // State register and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         deg_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         deg_q   <= deg_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state logic and status outputs; start is only honoured in
   // IDLE or DONE so a running division cannot be disturbed.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            busy = 1'b1;
            if (w_enc_zero) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath next-state: capture operands on an accepted start, set up
   // degree/counter in LOAD, and advance the long division in RUN.
   always_comb begin
      dvd_d = dvd_q;
      dvs_d = dvs_q;
      deg_d = deg_q;
      rem_d = rem_q;
      quo_d = quo_q;
      cnt_d = cnt_q;
      dbz_d = dbz_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               dvd_d = dividend;
               dvs_d = divisor;
               rem_d = '0;
               quo_d = '0;
               dbz_d = 1'b0;
            end
         end
         ST_LOAD: begin
            deg_d = w_enc_deg;
            cnt_d = CW'(RUN_STEPS - 1);
            rem_d = '0;
            quo_d = '0;
            dbz_d = w_enc_zero;
         end
         ST_RUN: begin
`ifdef GF2_DIV_RADIX4_EN
            rem_d = w_step_lo.rem;
            quo_d = {quo_q[PW-3:0], w_step_hi.qbit, w_step_lo.qbit};
            dvd_d = {dvd_q[PW-3:0], 2'b00};
`else
            rem_d = w_step_hi.rem;
            quo_d = {quo_q[PW-2:0], w_step_hi.qbit};
            dvd_d = {dvd_q[PW-2:0], 1'b0};
`endif
            cnt_d = cnt_q - CW'(1);
         end
         default: begin
         end
      endcase
   end

   assign dbz       = dbz_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_gf2_poly_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gf2_poly_divider
//  Description : Self-checking bench for gf2_poly_divider.  Expected results
//                come from a whole-polynomial long-division model; a compare
//                process checks busy/done/results every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gf2_poly_divider;

   localparam int N  = 571;
   localparam int PW = 1142;
`ifdef GF2_DIV_RADIX4_EN
   localparam int LAT = 572;
`else
   localparam int LAT = 1143;
`endif

   typedef struct {
      logic [PW-1:0] a;
      logic [N-1:0]  b;
      logic [PW-1:0] q;
      logic [N-1:0]  r;
      logic          z;
      int            acc;
      int            lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [PW-1:0] dividend;
   logic [N-1:0]  divisor;
   logic          busy, done, dbz;
   logic [PW-1:0] quotient;
   logic [N-1:0]  remainder;

   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   exp_t          expq[$];
   exp_t          held;
   exp_t          cur;
   logic          hold_valid;
   logic [PW+N-1:0] prod;

   gf2_poly_divider dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .dbz       (dbz),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [PW-1:0] ext(input logic [N-1:0] v);
      return {{(PW-N){1'b0}}, v};
   endfunction

   function automatic int degf(input logic [PW-1:0] v);
      for (int i = PW-1; i >= 0; i--) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // Textbook long division over GF(2) on the whole polynomial.
   task automatic model_div(input logic [PW-1:0] a, input logic [N-1:0] b,
                            output logic [PW-1:0] q, output logic [N-1:0] r,
                            output logic z);
      logic [PW-1:0] rr;
      int db;
      q  = '0;
      r  = '0;
      z  = (b == '0);
      if (!z) begin
         rr = a;
         db = degf(ext(b));
         for (int s = PW-1-db; s >= 0; s--) begin
            if (rr[s+db]) begin
               q[s] = 1'b1;
               rr   = rr ^ (ext(b) << s);
            end
         end
         r = rr[N-1:0];
      end
   endtask

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h (low 128 bits) at cycle %0d",
                  name, act[127:0], want[127:0], cyc);
      end
   endtask

   function automatic logic [PW-1:0] rand_pw();
      logic [PW-1:0] v;
      for (int i = 0; i < PW; i++) v[i] = 1'($urandom() & 1);
      return v;
   endfunction

   function automatic logic [N-1:0] rand_div();
      logic [N-1:0] v;
      int d;
      d = $urandom_range(N-1, 0);
      for (int i = 0; i < N; i++) v[i] = (i < d) ? 1'($urandom() & 1) : 1'b0;
      v[d] = 1'b1;
      return v;
   endfunction

   // Compare process: every cycle out of reset, check busy/done against the
   // outstanding-request model, results on done, and held values when idle.
   always @(negedge clk) begin
      if (!rst) begin
         logic exp_done;
         exp_done = (expq.size() != 0) && ((cyc - expq[0].acc) == expq[0].lat);
         chk("done", PW'(done), PW'(exp_done));
         chk("busy", PW'(busy), PW'((expq.size() != 0) && !exp_done));
         if (exp_done) begin
            cur = expq.pop_front();
            chk("quotient", quotient, cur.q);
            chk("remainder", ext(remainder), ext(cur.r));
            chk("dbz", PW'(dbz), PW'(cur.z));
            if (!cur.z) begin
               prod = '0;
               for (int i = 0; i < PW; i++) begin
                  if (quotient[i]) prod = prod ^ ({{PW{1'b0}}, cur.b} << i);
               end
               prod = prod ^ {{PW{1'b0}}, remainder};
               chk("prop_recon", prod[PW-1:0], cur.a);
               chk("prop_high", ext(prod[PW+N-1:PW]), '0);
               chk("prop_deg", PW'(degf(ext(remainder)) < degf(ext(cur.b))), PW'(1));
            end
            held       = cur;
            hold_valid = 1'b1;
         end else if (expq.size() == 0 && hold_valid) begin
            chk("hold_quotient", quotient, held.q);
            chk("hold_remainder", ext(remainder), ext(held.r));
            chk("hold_dbz", PW'(dbz), PW'(held.z));
         end
      end
   end

   // Call right after a negedge; start is accepted on the following posedge.
   task automatic issue(input logic [PW-1:0] a, input logic [N-1:0] b);
      exp_t e;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      model_div(a, b, e.q, e.r, e.z);
      e.a   = a;
      e.b   = b;
      e.acc = cyc;
      // Zero divisor: LOAD then DONE, i.e. done on the first edge after
      // the accepting edge (second cycle after the start cycle).
      e.lat = e.z ? 1 : LAT;
      hold_valid = 1'b0;
      expq.push_back(e);
   endtask

   task automatic finish_op();
      int n;
      n = 0;
      while (expq.size() != 0 && n < LAT + 20) begin
         @(negedge clk);
         n++;
      end
      if (expq.size() != 0) begin
         chk("timeout_pending", PW'(expq.size()), '0);
         expq.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_held();
      held.a = '0; held.b = '0; held.q = '0; held.r = '0; held.z = 1'b0;
      held.acc = 0; held.lat = 0;
      hold_valid = 1'b1;
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PW-1:0] mq, a;
      logic [N-1:0]  mr, b;
      logic          mz;
      int            n;

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; hold_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_held();
      @(negedge clk);
      chk("rst_busy", PW'(busy), '0);
      chk("rst_done", PW'(done), '0);
      chk("rst_quotient", quotient, '0);
      chk("rst_remainder", ext(remainder), '0);

      // Pin the model against hand-computed results.
      model_div(PW'(15), N'(3), mq, mr, mz);
      chk("model_pin_q_f3", mq, PW'(5));
      chk("model_pin_r_f3", ext(mr), '0);
      model_div(PW'(31), N'(7), mq, mr, mz);
      chk("model_pin_q_1f7", mq, PW'(4));
      chk("model_pin_r_1f7", ext(mr), PW'(3));

      // 0xF / 0x3
      issue(PW'(15), N'(3));
      finish_op();
      chk("lit_q_f3", quotient, PW'(5));
      chk("lit_r_f3", ext(remainder), '0);
      chk("lit_dbz_f3", PW'(dbz), '0);

      // 0x1F / 0x7
      issue(PW'(31), N'(7));
      finish_op();
      chk("lit_q_1f7", quotient, PW'(4));
      chk("lit_r_1f7", ext(remainder), PW'(3));

      // x^1141 / x^570 -> x^571
      a = '0; a[PW-1] = 1'b1;
      b = '0; b[N-1]  = 1'b1;
      mq = '0; mq[571] = 1'b1;
      issue(a, b);
      finish_op();
      chk("lit_q_top", quotient, mq);
      chk("lit_r_top", ext(remainder), '0);

      // divisor 1
      a = rand_pw();
      issue(a, N'(1));
      finish_op();
      chk("lit_q_div1", quotient, a);
      chk("lit_r_div1", ext(remainder), '0);

      // dividend degree below divisor degree
      issue(PW'(5), N'(19));
      finish_op();
      chk("lit_r_small", ext(remainder), PW'(5));

      // zero divisor, then a restart from DONE with divisor 0x3
      issue(PW'(15), '0);
      n = 0;
      @(negedge clk);
      while (!done && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("zero_div_done", PW'(done), PW'(1));
      chk("zero_div_dbz", PW'(dbz), PW'(1));
      issue(PW'(15), N'(3));
      finish_op();
      chk("restart_dbz_clear", PW'(dbz), '0);
      chk("restart_q", quotient, PW'(5));

      // start re-pulsed at RUN cycle 100 is ignored
      a = rand_pw();
      b = rand_div();
      issue(a, b);
      repeat (101) @(negedge clk);
      dividend = rand_pw();
      divisor  = N'(3);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_op();

      // reset at RUN cycle 500 aborts; a new division then completes
      issue(rand_pw(), rand_div());
      repeat (501) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expq.delete();
      clear_held();
      repeat (5) @(negedge clk);
      chk("abort_quotient", quotient, '0);
      chk("abort_remainder", ext(remainder), '0);
      chk("abort_busy", PW'(busy), '0);
      issue(PW'(31), N'(7));
      finish_op();
      chk("post_abort_q", quotient, PW'(4));
      chk("post_abort_r", ext(remainder), PW'(3));

      // random pairs
      for (int k = 0; k < 20; k++) begin
         issue(rand_pw(), rand_div());
         finish_op();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
